// File: rtl/ysyx_210238_sram_responder_pkg.sv
// Shared definitions for the SRAM responder and its lane-alignment helper:
// transfer size codes, FSM states, default base address and lane mask helpers.
package ysyx_210238_sram_responder_pkg;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Bytes covered by a transfer of the given size, starting at lane 0.
    function automatic logic [7:0] size_lane_mask(input logic [2:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            SIZE_D:  return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned transfer.
    function automatic logic [2:0] align_mask(input logic [1:0] size_lo);
        case (size_lo)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_210238_sram_responder_lane_align.sv
// Combinational lane logic for 64-bit word memories: request legality, word
// index, byte write mask, write-data lane shift and read-data extraction.
module ysyx_210238_lane_align
    import ysyx_210238_sram_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          AW        = 16
) (
    input  logic [63:0]   addr,
    input  logic [2:0]    size,
    input  logic [63:0]   wdata,
    input  logic [63:0]   rword,
    output logic          legal,
    output logic [AW-1:0] word_idx,
    output logic [7:0]    bmask,
    output logic [63:0]   wshift,
    output logic [63:0]   rext
);

    localparam logic [63:0] SPAN = 64'd1 << (AW + 3);

    logic [63:0] offset;
    logic [2:0]  lane;
    logic [7:0]  lane_mask;
    logic [5:0]  bit_shift;
    logic [63:0] rshift;

    // NOTE: every output of this block is assigned before any conditional use,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        offset    = addr - BASE_ADDR;
        lane      = addr[2:0];
        lane_mask = size_lane_mask(size);
        bit_shift = {lane, 3'b000};

        // The lower bound is checked explicitly because the subtraction wraps.
        legal = !size[2]
             && ((lane & align_mask(size[1:0])) == 3'b000)
             && (addr >= BASE_ADDR)
             && (offset < SPAN);

        word_idx = offset[AW+2:3];
        bmask    = lane_mask << lane;
        wshift   = wdata << bit_shift;
        rshift   = rword >> bit_shift;

        rext = '0;
        for (int b = 0; b < 8; b++) begin
            rext[8*b +: 8] = lane_mask[b] ? rshift[8*b +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/ysyx_210238_sram_responder.sv
// Responder for the core's valid/ready RAM bus onto a single-port synchronous
// SRAM of 64-bit words: one request at a time, programmable wait states.
module ysyx_210238_sram_responder
    import ysyx_210238_sram_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          AW          = 16,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_ram_valid,
    input  logic [63:0]   i_ram_addr,
    input  logic          i_ram_wen,
    input  logic [63:0]   i_ram_wdata,
    input  logic [2:0]    i_ram_size,
    output logic          o_ram_ready,
    output logic [63:0]   o_ram_rdata,
    output logic          o_ram_err,

    output logic          o_sram_en,
    output logic          o_sram_we,
    output logic [AW-1:0] o_sram_addr,
    output logic [7:0]    o_sram_bmask,
    output logic [63:0]   o_sram_wdata,
    input  logic [63:0]   i_sram_rdata
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;

    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [2:0]  req_size;

    logic        acc_d1;
    logic [63:0] rdata_q;
    logic [63:0] rword;

    logic          legal;
    logic [AW-1:0] word_idx;
    logic [7:0]    bmask;
    logic [63:0]   wshift;
    logic [63:0]   rext;

    // The SRAM word is live on its output only in the cycle after ACC; later
    // responses (wait states) take the copy held in rdata_q.
    assign rword = acc_d1 ? i_sram_rdata : rdata_q;

    ysyx_210238_lane_align #(
        .BASE_ADDR (BASE_ADDR),
        .AW        (AW)
    ) u_lane_align (
        .addr     (req_addr),
        .size     (req_size),
        .wdata    (req_wdata),
        .rword    (rword),
        .legal    (legal),
        .word_idx (word_idx),
        .bmask    (bmask),
        .wshift   (wshift),
        .rext     (rext)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_addr  <= '0;
            req_wen   <= 1'b0;
            req_wdata <= '0;
            req_size  <= '0;
            acc_d1    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state  <= next_state;
            acc_d1 <= (state == ST_ACC);

            if (state == ST_IDLE && i_ram_valid) begin
                req_addr  <= i_ram_addr;
                req_wen   <= i_ram_wen;
                req_wdata <= i_ram_wdata;
                req_size  <= i_ram_size;
            end

            if (state == ST_ACC) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (acc_d1) begin
                rdata_q <= i_sram_rdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (i_ram_valid) next_state = ST_ACC;
            ST_ACC:  next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wait_cnt == 4'd1) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs decode from the state register and the request latch only, so
    // i_ram_* never reaches o_ram_* within a cycle.
    always_comb begin
        o_sram_en    = 1'b0;
        o_sram_we    = 1'b0;
        o_sram_addr  = '0;
        o_sram_bmask = '0;
        o_sram_wdata = '0;
        o_ram_ready  = 1'b0;
        o_ram_err    = 1'b0;
        o_ram_rdata  = '0;

        if (state == ST_ACC && legal) begin
            o_sram_en    = 1'b1;
            o_sram_we    = req_wen;
            o_sram_addr  = word_idx;
            o_sram_bmask = req_wen ? bmask : 8'h00;
            o_sram_wdata = req_wen ? wshift : 64'h0;
        end

        if (state == ST_RESP) begin
            o_ram_ready = 1'b1;
            o_ram_err   = !legal;
            if (legal && !req_wen) begin
                o_ram_rdata = rext;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_210238_sram_responder.sv
// Directed bench: one responder with no wait states and one with three, each
// backed by a small behavioural SRAM with byte-masked writes.
module tb_ysyx_210238_sram_responder;

    logic        clk;
    logic        rst;

    logic        valid  [2];
    logic [63:0] addr   [2];
    logic        wen    [2];
    logic [63:0] wdata  [2];
    logic [2:0]  size   [2];
    logic        ready  [2];
    logic [63:0] rdata  [2];
    logic        err    [2];
    logic        sram_en    [2];
    logic        sram_we    [2];
    logic [15:0] sram_addr  [2];
    logic [7:0]  sram_bmask [2];
    logic [63:0] sram_wdata [2];
    logic [63:0] sram_rdata [2];

    logic [63:0] mem [2][65536];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ysyx_210238_sram_responder #(.AW(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_ram_valid(valid[0]), .i_ram_addr(addr[0]), .i_ram_wen(wen[0]),
        .i_ram_wdata(wdata[0]), .i_ram_size(size[0]),
        .o_ram_ready(ready[0]), .o_ram_rdata(rdata[0]), .o_ram_err(err[0]),
        .o_sram_en(sram_en[0]), .o_sram_we(sram_we[0]), .o_sram_addr(sram_addr[0]),
        .o_sram_bmask(sram_bmask[0]), .o_sram_wdata(sram_wdata[0]),
        .i_sram_rdata(sram_rdata[0])
    );

    ysyx_210238_sram_responder #(.AW(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_ram_valid(valid[1]), .i_ram_addr(addr[1]), .i_ram_wen(wen[1]),
        .i_ram_wdata(wdata[1]), .i_ram_size(size[1]),
        .o_ram_ready(ready[1]), .o_ram_rdata(rdata[1]), .o_ram_err(err[1]),
        .o_sram_en(sram_en[1]), .o_sram_we(sram_we[1]), .o_sram_addr(sram_addr[1]),
        .o_sram_bmask(sram_bmask[1]), .o_sram_wdata(sram_wdata[1]),
        .i_sram_rdata(sram_rdata[1])
    );

    // Synchronous SRAM models: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sram_en[d]) begin
                if (sram_we[d]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (sram_bmask[d][b]) mem[d][sram_addr[d]][8*b +: 8] <= sram_wdata[d][8*b +: 8];
                    end
                end else begin
                    sram_rdata[d] <= mem[d][sram_addr[d]];
                end
            end
        end
    end

    // Issues one request and follows it to its ready pulse. lat counts cycles
    // from the IDLE cycle that first sees valid (cycle 0).
    task automatic do_req(input int d, input logic [63:0] a, input logic w,
                          input logic [63:0] wd, input logic [2:0] sz,
                          output logic [63:0] rd, output logic er, output int lat,
                          output int ens, output logic [7:0] acc_mask,
                          output logic [63:0] acc_wdata, output logic [15:0] acc_addr);
        @(negedge clk);
        valid[d] = 1'b1; addr[d] = a; wen[d] = w; wdata[d] = wd; size[d] = sz;
        lat = 0; ens = 0; rd = '0; er = 1'b0;
        acc_mask = '0; acc_wdata = '0; acc_addr = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (sram_en[d]) begin
                ens++;
                acc_mask = sram_bmask[d]; acc_wdata = sram_wdata[d]; acc_addr = sram_addr[d];
            end
            if (ready[d]) begin
                lat = n; rd = rdata[d]; er = err[d];
                break;
            end
        end
        valid[d] = 1'b0;
        total++;
        if (lat == 0) begin
            bad++;
            $display("FAIL req_timeout dut=%0d addr=%h: no ready within 40 cycles", d, a);
        end
        @(negedge clk);
        total++;
        if (ready[d] !== 1'b0) begin
            bad++;
            $display("FAIL ready_single_pulse dut=%0d: ready=%b in cycle after response, want 0", d, ready[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0; addr[d] = '0; wen[d] = 1'b0; wdata[d] = '0; size[d] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({ready[d], err[d], sram_en[d], sram_we[d], rdata[d], sram_addr[d],
                 sram_bmask[d], sram_wdata[d]} !== '0) begin
                bad++;
                $display("FAIL reset_outputs dut=%0d: ready=%b err=%b en=%b we=%b rdata=%h addr=%h bmask=%h wdata=%h, want all 0",
                         d, ready[d], err[d], sram_en[d], sram_we[d], rdata[d], sram_addr[d], sram_bmask[d], sram_wdata[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dword();
        logic [63:0] rd, aw; logic er; int lat, ens; logic [7:0] am; logic [15:0] aa;
        do_req(0, 64'h8000_0000, 1'b1, 64'h1122_3344_5566_7788, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (lat !== 2 || er !== 1'b0 || rd !== 64'h0 || ens !== 1 || am !== 8'hFF) begin
            bad++;
            $display("FAIL dword_write: lat=%0d err=%b rdata=%h en=%0d bmask=%h, want 2 0 0 1 ff", lat, er, rd, ens, am);
        end
        do_req(0, 64'h8000_0000, 1'b0, 64'h0, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (lat !== 2 || er !== 1'b0 || rd !== 64'h1122_3344_5566_7788 || ens !== 1) begin
            bad++;
            $display("FAIL dword_read: lat=%0d err=%b rdata=%h en=%0d, want 2 0 1122334455667788 1", lat, er, rd, ens);
        end
    endtask

    task automatic test_byte_write();
        logic [63:0] rd, aw; logic er; int lat, ens; logic [7:0] am; logic [15:0] aa;
        do_req(0, 64'h8000_0005, 1'b1, 64'hAB, 3'd0, rd, er, lat, ens, am, aw, aa);
        total++;
        if (am !== 8'b0010_0000 || aw !== 64'h0000_AB00_0000_0000 || aa !== 16'h0 || ens !== 1 || er !== 1'b0) begin
            bad++;
            $display("FAIL byte_write_lanes: bmask=%b wdata=%h addr=%h en=%0d err=%b, want 00100000 0000ab0000000000 0 1 0",
                     am, aw, aa, ens, er);
        end
        do_req(0, 64'h8000_0000, 1'b0, 64'h0, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (rd !== 64'h1122_AB44_5566_7788) begin
            bad++;
            $display("FAIL byte_write_readback: rdata=%h, want 1122ab4455667788", rd);
        end
    endtask

    task automatic test_halfword();
        logic [63:0] rd, aw; logic er; int lat, ens; logic [7:0] am; logic [15:0] aa;
        do_req(0, 64'h8000_0008, 1'b1, 64'hFFEE_DDCC_BBAA_9988, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (aa !== 16'h1 || aw !== 64'hFFEE_DDCC_BBAA_9988) begin
            bad++;
            $display("FAIL word1_write: addr=%h wdata=%h, want 0001 ffeeddccbbaa9988", aa, aw);
        end
        do_req(0, 64'h8000_000E, 1'b0, 64'h0, 3'd1, rd, er, lat, ens, am, aw, aa);
        total++;
        if (rd !== 64'h0000_0000_0000_FFEE || er !== 1'b0 || lat !== 2) begin
            bad++;
            $display("FAIL half_read: rdata=%h err=%b lat=%0d, want 000000000000ffee 0 2", rd, er, lat);
        end
        do_req(0, 64'h8000_000C, 1'b0, 64'h0, 3'd2, rd, er, lat, ens, am, aw, aa);
        total++;
        if (rd !== 64'h0000_0000_FFEE_DDCC) begin
            bad++;
            $display("FAIL word_read: rdata=%h, want 00000000ffeeddcc", rd);
        end
        do_req(0, 64'h8000_0009, 1'b0, 64'h0, 3'd0, rd, er, lat, ens, am, aw, aa);
        total++;
        if (rd !== 64'h0000_0000_0000_0099) begin
            bad++;
            $display("FAIL byte_read: rdata=%h, want 0000000000000099", rd);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd, aw; logic er; int lat, ens; logic [7:0] am; logic [15:0] aa;
        logic [63:0] e_addr [5];
        logic        e_wen  [5];
        logic [2:0]  e_size [5];
        e_addr[0] = 64'h7FFF_FFF8; e_wen[0] = 1'b0; e_size[0] = 3'd3;
        e_addr[1] = 64'h8000_0003; e_wen[1] = 1'b1; e_size[1] = 3'd2;
        e_addr[2] = 64'h8000_0000; e_wen[2] = 1'b0; e_size[2] = 3'd5;
        e_addr[3] = 64'h8008_0000; e_wen[3] = 1'b0; e_size[3] = 3'd3;
        e_addr[4] = 64'h8000_0006; e_wen[4] = 1'b1; e_size[4] = 3'd2;
        for (int i = 0; i < 5; i++) begin
            do_req(0, e_addr[i], e_wen[i], 64'hDEAD_BEEF_DEAD_BEEF, e_size[i], rd, er, lat, ens, am, aw, aa);
            total++;
            if (er !== 1'b1 || rd !== 64'h0 || ens !== 0 || lat !== 2) begin
                bad++;
                $display("FAIL error_case%0d addr=%h size=%0d: err=%b rdata=%h en=%0d lat=%0d, want 1 0 0 2",
                         i, e_addr[i], e_size[i], er, rd, ens, lat);
            end
        end
        do_req(0, 64'h8000_0000, 1'b0, 64'h0, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (rd !== 64'h1122_AB44_5566_7788) begin
            bad++;
            $display("FAIL error_no_side_effect: rdata=%h, want 1122ab4455667788", rd);
        end
        do_req(0, 64'h8007_FFF8, 1'b0, 64'h0, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (er !== 1'b0 || aa !== 16'hFFFF || ens !== 1) begin
            bad++;
            $display("FAIL last_word_legal: err=%b addr=%h en=%0d, want 0 ffff 1", er, aa, ens);
        end
    endtask

    task automatic test_wait_states();
        logic [63:0] rd, aw; logic er; int lat, ens; logic [7:0] am; logic [15:0] aa;
        do_req(1, 64'h8000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (lat !== 5 || ens !== 1 || aa !== 16'h2 || er !== 1'b0) begin
            bad++;
            $display("FAIL wait_write: lat=%0d en=%0d addr=%h err=%b, want 5 1 0002 0", lat, ens, aa, er);
        end
        do_req(1, 64'h8000_0010, 1'b0, 64'h0, 3'd3, rd, er, lat, ens, am, aw, aa);
        total++;
        if (lat !== 5 || rd !== 64'h0123_4567_89AB_CDEF) begin
            bad++;
            $display("FAIL wait_read: lat=%0d rdata=%h, want 5 0123456789abcdef", lat, rd);
        end
    endtask

    task automatic test_back_to_back();
        int r1, r2, ens, pulses;
        logic [63:0] d1, d2;
        r1 = 0; r2 = 0; ens = 0; pulses = 0; d1 = '0; d2 = '0;
        @(negedge clk);
        valid[1] = 1'b1; addr[1] = 64'h8000_0010; wen[1] = 1'b0; size[1] = 3'd3;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (sram_en[1]) ens++;
            if (ready[1]) begin
                pulses++;
                if (r1 == 0) begin
                    r1 = n; d1 = rdata[1];
                    addr[1] = 64'h8000_0014; size[1] = 3'd2;
                end else if (r2 == 0) begin
                    r2 = n; d2 = rdata[1];
                    valid[1] = 1'b0;
                end
            end
        end
        valid[1] = 1'b0;
        total++;
        if (r1 !== 5 || r2 !== 11 || pulses !== 2) begin
            bad++;
            $display("FAIL b2b_timing: ready at %0d and %0d, pulses=%0d, want 5 11 2", r1, r2, pulses);
        end
        total++;
        if (ens !== 2) begin
            bad++;
            $display("FAIL b2b_en_pulses: en=%0d, want 2", ens);
        end
        total++;
        if (d1 !== 64'h0123_4567_89AB_CDEF || d2 !== 64'h0000_0000_0123_4567) begin
            bad++;
            $display("FAIL b2b_data: first=%h second=%h, want 0123456789abcdef 0000000001234567", d1, d2);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd, aw; logic er; int lat, ens, pulses; logic [7:0] am; logic [15:0] aa;
        pulses = 0;
        @(negedge clk);
        valid[1] = 1'b1; addr[1] = 64'h8000_0010; wen[1] = 1'b0; size[1] = 3'd3;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready[1]) pulses++;
        end
        rst = 1'b1;
        valid[1] = 1'b0;
        #1;
        total++;
        if ({ready[1], err[1], sram_en[1], sram_we[1], rdata[1], sram_addr[1],
             sram_bmask[1], sram_wdata[1]} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: ready=%b err=%b en=%b rdata=%h addr=%h, want all 0",
                     ready[1], err[1], sram_en[1], rdata[1], sram_addr[1]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ready[1]) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL reset_mid_no_ready: ready pulses=%0d, want 0", pulses);
        end
        do_req(1, 64'h8000_0010, 1'b0, 64'h0, 3'd0, rd, er, lat, ens, am, aw, aa);
        total++;
        if (lat !== 5 || rd !== 64'h0000_0000_0000_00EF || er !== 1'b0) begin
            bad++;
            $display("FAIL reset_recover: lat=%0d rdata=%h err=%b, want 5 00000000000000ef 0", lat, rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_dword();
        test_byte_write();
        test_halfword();
        test_errors();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
